dso_buffer_reader: RTL and testbench
====================================

// Module: dso_buffer_reader
// PURPOSE
//  Downstream readout stage of the DSO capture path. Accepts a completed capture
//  (valid + trigger address) from the ADC driver, then streams the circular sample buffer as bytes to the SPI slave.
//  Streaming starts PRE_SAMPLES words before the trigger and wraps mod 2^DEPTH.
//  While idle it signals ready upstream; it holds ready low during readout so no new capture overwrites the buffer.
// PARAMETERS
//  DEPTH        6    buffer address width; frame = 2^DEPTH words of 16 bits; DEPTH<=8
//  PRE_SAMPLES  8    words emitted before trigger word; < 2^DEPTH
// PORTS
//  clk            in   1      system clock, all logic on posedge
//  rst            in   1      asynchronous reset, active-high
//  capture_valid  in   1      capture complete, buffer frozen (from ADC driver valid)
//  trig_addr      in   DEPTH  buffer address of trigger sample, sampled on handshake
//  capture_ready  out  1      reader idle, may accept capture (to ADC driver ready)
//  rd_en          out  1      buffer read strobe
//  rd_addr        out  DEPTH  buffer read address
//  rd_data        in   16     buffer read data, valid 1 cycle after rd_en
//  out_data       out  8      stream byte
//  out_valid      out  1      out_data valid
//  out_ready      in   1      SPI side accepts byte when out_valid&out_ready
//  busy           out  1      frame in progress (= ~capture_ready after reset)
// BEHAVIOUR
//  - Reset (async): state IDLE, all outputs 0 incl. capture_ready.
//    capture_ready rises on first clk edge after rst deasserts.
//  - All outputs registered. Capture handshake = capture_valid & capture_ready on a clk edge.
//    On it: start = trig_addr - PRE_SAMPLES (mod 2^DEPTH), word_cnt=0; capture_ready drops next cycle.
//  - FSM: IDLE -> [HDR0 -> HDR1 ->] FETCH -> WAIT -> HI -> LO -> (FETCH | DONE) -> IDLE.
//    FETCH: rd_en=1 for one cycle, rd_addr = start + word_cnt (wraps 2^DEPTH-1 -> 0).
//    WAIT: rd_data latched into word register.
//    HI: out_data=word[15:8], out_valid=1 until accepted.
//    LO: out_data=word[7:0], out_valid=1 until accepted.
//    After LO accept: word_cnt+1; word_cnt (DEPTH+1 bits) == 2^DEPTH -> DONE, else FETCH.
//    DONE: one cycle; capture_ready=1 on entry to IDLE.
//  - Latency: handshake edge -> first out_valid = 3 cycles (no header).
//    Frame = 2^(DEPTH+1) bytes, high byte first.
//  - out_data/out_valid held stable while out_valid & ~out_ready; no byte dropped or repeated.
//  - capture_valid while busy: ignored, no state change. trig_addr changes mid-frame: ignored.
//  - rst mid-frame: frame abandoned, out_valid/rd_en 0 immediately (async); restart only via a new capture.
//  - out_ready held low forever: block stalls in HI/LO, no timeout.
// CONFIGURATION
//  DSO_RDR_HEADER_EN defined: frame prefixed by 2 bytes (HDR0, HDR1) with the same valid/ready rule.
//    Bytes: 0xA5 (sync), then trig position {{(8-DEPTH){1'b0}}, PRE_SAMPLES[DEPTH-1:0]}.
//    First out_valid 1 cycle after handshake; frame = 2^(DEPTH+1)+2 bytes.
//  Undefined: HDR states absent, IDLE -> FETCH directly.
// STRUCTURE
//  Shared include dso_defs.vh: FSM state encodings, DSO_SYNC_BYTE = 8'hA5,
//  byte-order constant, used by the SPI slave decoder.
//  Sub-module: dso_word_serializer (16-bit load -> 2 bytes over valid/ready, HI/LO sequencing).
//  Top holds the FSM, address/word counters, and header mux.
// TESTING (DEPTH=6, PRE_SAMPLES=8, out_ready=1 unless stated)
//  1 trig_addr=0x10, capture_valid pulse -> rd_addr 0x08..0x3F,0x00..0x07; 128 bytes; out_data = ramp bytes hi/lo;
//    capture_ready low from next edge until 1 cycle after DONE.
//  2 trig_addr=0x03 -> first rd_addr 0x3B, wraps 0x3F->0x00, last rd_addr 0x3A; exactly 64 rd_en pulses.
//  3 out_ready toggled 1-of-3 cycles random -> byte sequence identical to test 1;
//    out_data stable whenever out_valid&~out_ready.
//  4 rst asserted at byte 40 for 2 cycles -> out_valid,rd_en,capture_ready 0 same cycle;
//    capture_ready=1 first edge after release; next capture starts fresh.
//  5 capture_valid held high during frame, trig_addr changed to 0x20 -> no restart; frame per original 0x10 finishes.
//  6 DSO_RDR_HEADER_EN, trig_addr=0x10 -> bytes 0xA5, 0x08, then 128 data bytes; first out_valid 1 cycle after handshake.

Source files
------------

// File: rtl/dso_buffer_reader_pkg.sv
// dso_buffer_reader_pkg
//  Shared definitions for the DSO readout path: reader FSM state encoding,
//  the frame sync byte, the byte-order constant and a helper that forms the
//  trigger-position header byte. The SPI slave decoder imports the same
//  package, so both ends agree on framing.
//  No ports (package).

package dso_buffer_reader_pkg;

    // Reader FSM states. HDR0/HDR1 are only reachable when the frame header
    // is compiled in.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR0  = 3'd1,
        ST_HDR1  = 3'd2,
        ST_FETCH = 3'd3,
        ST_WAIT  = 3'd4,
        ST_HI    = 3'd5,
        ST_LO    = 3'd6,
        ST_DONE  = 3'd7
    } rdr_state_e;

    // First header byte, lets the receiver find frame boundaries.
    localparam logic [7:0] DSO_SYNC_BYTE = 8'hA5;

    // Each 16-bit sample leaves as two bytes, most significant byte first.
    localparam bit DSO_BYTE_ORDER_HI_FIRST = 1'b1;

    // Trigger position inside the frame, reduced to the buffer address width
    // and zero-extended to one byte.
    function automatic logic [7:0] trig_pos_byte(input int depth, input int pre);
        return 8'(pre % (1 << depth));
    endfunction

endpackage

// File: rtl/dso_word_serializer.sv
// dso_word_serializer
//  Turns a 16-bit word into two bytes on a valid/ready stream. A "single"
//  load emits only load_data[7:0]; the reader uses it for header bytes.
//  A new load may be applied in the same cycle the last byte is accepted,
//  which keeps out_valid high without a bubble.
//  Ports:
//   clk, rst        clock, asynchronous active-high reset
//   load            take load_data this cycle (only when empty or on last accept)
//   load_single     emit one byte (load_data[7:0]) instead of two
//   load_data[15:0] word to serialize
//   out_ready       downstream accepts byte when out_valid & out_ready
//   out_data[7:0]   stream byte (registered)
//   out_valid       stream valid (registered)
//   accept          out_valid & out_ready this cycle
//   last            the byte currently offered is the final byte of the load

module dso_word_serializer #(
    parameter bit HI_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        load_single,
    input  logic [15:0] load_data,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        accept,
    output logic        last
);

    logic       valid_q, valid_d;
    logic       more_q, more_d;
    logic [7:0] data_q, data_d;
    logic [7:0] second_q, second_d;
    logic [7:0] first_byte, other_byte;

    assign first_byte = HI_FIRST ? load_data[15:8] : load_data[7:0];
    assign other_byte = HI_FIRST ? load_data[7:0]  : load_data[15:8];

    // Holding state is the default, so an offered byte stays put while the
    // receiver stalls. A load overrides the emptying caused by a last accept.
    always_comb begin
        valid_d  = valid_q;
        more_d   = more_q;
        data_d   = data_q;
        second_d = second_q;
        accept   = valid_q & out_ready;
        last     = ~more_q;

        if (accept) begin
            if (more_q) begin
                data_d = second_q;
                more_d = 1'b0;
            end else begin
                valid_d = 1'b0;
            end
        end

        if (load) begin
            valid_d  = 1'b1;
            more_d   = ~load_single;
            data_d   = load_single ? load_data[7:0] : first_byte;
            second_d = other_byte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            more_q   <= 1'b0;
            data_q   <= '0;
            second_q <= '0;
        end else begin
            valid_q  <= valid_d;
            more_q   <= more_d;
            data_q   <= data_d;
            second_q <= second_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;

endmodule

// File: rtl/dso_buffer_reader.sv
// dso_buffer_reader
//  Readout stage of the DSO capture path. After a capture handshake it reads
//  the whole circular sample buffer, starting PRE_SAMPLES words before the
//  trigger address and wrapping mod 2^DEPTH, and streams every 16-bit word
//  as two bytes (high first) to the SPI slave. capture_ready is held low for
//  the whole frame so the ADC driver cannot overwrite the buffer.
//  Optional build macro DSO_RDR_HEADER_EN: prefixes each frame with the sync
//  byte 0xA5 and the trigger position byte.
//  Ports:
//   clk, rst            clock, asynchronous active-high reset
//   capture_valid       capture complete, buffer frozen
//   trig_addr[DEPTH]    trigger sample address, taken on the handshake
//   capture_ready       reader idle, may accept a capture
//   rd_en, rd_addr      buffer read strobe/address; rd_data valid one cycle later
//   rd_data[16]         buffer read data
//   out_data[8]         stream byte
//   out_valid/out_ready stream handshake
//   busy                frame in progress

module dso_buffer_reader
    import dso_buffer_reader_pkg::*;
#(
    parameter int DEPTH       = 6,
    parameter int PRE_SAMPLES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture_valid,
    input  logic [DEPTH-1:0] trig_addr,
    output logic             capture_ready,
    output logic             rd_en,
    output logic [DEPTH-1:0] rd_addr,
    input  logic [15:0]      rd_data,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam logic [DEPTH-1:0] PRE_OFF     = DEPTH'(PRE_SAMPLES);
    localparam logic [DEPTH:0]   FRAME_WORDS = (DEPTH+1)'(1 << DEPTH);

    rdr_state_e       state_q, state_d;
    logic [DEPTH-1:0] start_q, start_d;
    logic [DEPTH:0]   cnt_q, cnt_d;
    logic [DEPTH-1:0] rd_addr_q, rd_addr_d;
    logic             rd_en_q, rd_en_d;
    logic             cap_ready_q, cap_ready_d;
    logic             busy_q, busy_d;

    logic             handshake;
    logic             ser_load, ser_single;
    logic [15:0]      ser_data;
    logic             ser_accept, ser_last;

    // cap_ready_q is only ever high in IDLE, so a handshake can never
    // disturb a frame in progress.
    assign handshake = capture_valid & cap_ready_q;

    // Next-state logic. Outputs are registered from the next state so that
    // each state's strobe is visible in exactly the cycle the FSM is in it.
    always_comb begin
        state_d    = state_q;
        start_d    = start_q;
        cnt_d      = cnt_q;
        ser_load   = 1'b0;
        ser_single = 1'b0;
        ser_data   = rd_data;

        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    start_d = trig_addr - PRE_OFF;
                    cnt_d   = '0;
`ifdef DSO_RDR_HEADER_EN
                    state_d    = ST_HDR0;
                    ser_load   = 1'b1;
                    ser_single = 1'b1;
                    ser_data   = {8'h00, DSO_SYNC_BYTE};
`else
                    state_d = ST_FETCH;
`endif
                end
            end
`ifdef DSO_RDR_HEADER_EN
            // The position byte is loaded in the same cycle the sync byte
            // leaves, so the header goes out back to back.
            ST_HDR0: begin
                if (ser_accept) begin
                    state_d    = ST_HDR1;
                    ser_load   = 1'b1;
                    ser_single = 1'b1;
                    ser_data   = {8'h00, trig_pos_byte(DEPTH, PRE_SAMPLES)};
                end
            end
            ST_HDR1: begin
                if (ser_accept) begin
                    state_d = ST_FETCH;
                end
            end
`endif
            ST_FETCH: state_d = ST_WAIT;
            // rd_data belongs to the address strobed in FETCH here.
            ST_WAIT: begin
                state_d  = ST_HI;
                ser_load = 1'b1;
            end
            ST_HI: begin
                if (ser_accept) begin
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                if (ser_accept && ser_last) begin
                    cnt_d   = cnt_q + (DEPTH+1)'(1);
                    state_d = (cnt_d == FRAME_WORDS) ? ST_DONE : ST_FETCH;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        rd_en_d     = (state_d == ST_FETCH);
        rd_addr_d   = rd_en_d ? (start_d + cnt_d[DEPTH-1:0]) : rd_addr_q;
        cap_ready_d = (state_d == ST_IDLE);
        busy_d      = ~cap_ready_d;
    end

    // Reset leaves every output low, including capture_ready; it rises on
    // the first edge after release because the next state is IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            start_q     <= '0;
            cnt_q       <= '0;
            rd_addr_q   <= '0;
            rd_en_q     <= 1'b0;
            cap_ready_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            cnt_q       <= cnt_d;
            rd_addr_q   <= rd_addr_d;
            rd_en_q     <= rd_en_d;
            cap_ready_q <= cap_ready_d;
            busy_q      <= busy_d;
        end
    end

    dso_word_serializer #(
        .HI_FIRST (DSO_BYTE_ORDER_HI_FIRST)
    ) u_ser (
        .clk         (clk),
        .rst         (rst),
        .load        (ser_load),
        .load_single (ser_single),
        .load_data   (ser_data),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .accept      (ser_accept),
        .last        (ser_last)
    );

    assign capture_ready = cap_ready_q;
    assign rd_en         = rd_en_q;
    assign rd_addr       = rd_addr_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_dso_buffer_reader.sv
// tb_dso_buffer_reader
//  Bench for dso_buffer_reader with DEPTH=6, PRE_SAMPLES=8. A behavioural
//  buffer memory answers reads one cycle after rd_en; expected frames are
//  built from the buffer contents and the trigger address with plain
//  modular arithmetic.

module tb_dso_buffer_reader;

    localparam int DEPTH = 6;
    localparam int PRE   = 8;
    localparam int WORDS = 1 << DEPTH;

    logic             clk;
    logic             rst;
    logic             capture_valid;
    logic [DEPTH-1:0] trig_addr;
    logic             capture_ready;
    logic             rd_en;
    logic [DEPTH-1:0] rd_addr;
    logic [15:0]      rd_data;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    int vec_cnt;
    int miss_cnt;

    logic [15:0]      mem [WORDS];
    logic [7:0]       got_bytes [$];
    logic [DEPTH-1:0] got_addrs [$];
    int               stab_err;
    bit               prev_stall;
    logic [7:0]       prev_data;

    dso_buffer_reader #(
        .DEPTH       (DEPTH),
        .PRE_SAMPLES (PRE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .capture_valid (capture_valid),
        .trig_addr     (trig_addr),
        .capture_ready (capture_ready),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous buffer: data for an address strobed in one cycle appears
    // in the next.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    // Stream monitor: records accepted bytes and strobed addresses, and
    // counts any change of a byte that was offered but not taken.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data)) stab_err++;
            if (out_valid && out_ready) got_bytes.push_back(out_data);
            if (rd_en) got_addrs.push_back(rd_addr);
            prev_stall = out_valid & ~out_ready;
            prev_data  = out_data;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vec_cnt++;
        assert (observed === expected) else begin
            miss_cnt++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic fillBuffer();
        for (int i = 0; i < WORDS; i++) mem[i] = 16'($urandom);
    endtask

    // Presents a capture and waits for the handshake edge.
    task automatic applyStimulus(input logic [DEPTH-1:0] trig);
        @(posedge clk);
        #1;
        capture_valid = 1'b1;
        trig_addr     = trig;
        @(posedge clk);
    endtask

    // Runs one frame and compares it with the reference frame. abort_at >= 0
    // returns early once that many bytes have been accepted.
    task automatic runFrame(input logic [DEPTH-1:0] trig, input bit rnd_ready,
                            input bit hold_valid, input int abort_at);
        int               lat;
        int               busy_err;
        bit               done;
        int               exp_lat;
        logic [7:0]       exp_b [$];
        logic [DEPTH-1:0] exp_a [$];

        got_bytes.delete();
        got_addrs.delete();
        stab_err = 0;
        lat      = -1;
        busy_err = 0;
        done     = 1'b0;

        applyStimulus(trig);
        #1;
        if (hold_valid) trig_addr = 6'h20;
        else            capture_valid = 1'b0;
        out_ready = rnd_ready ? ($urandom_range(0, 2) == 0) : 1'b1;

        for (int cyc = 1; cyc < 4000 && !done; cyc++) begin
            @(negedge clk);
            #2;
            if (lat < 0 && out_valid) lat = cyc;
            if (cyc == 1) checkOutput("ready_drop", 32'(capture_ready), 32'd0);
            if (busy !== ~capture_ready) busy_err++;
            if (hold_valid && got_bytes.size() >= 100) capture_valid = 1'b0;
            if (abort_at >= 0 && got_bytes.size() >= abort_at) return;
            if (capture_ready) begin
                done = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                out_ready = rnd_ready ? ($urandom_range(0, 2) == 0) : 1'b1;
            end
        end
        out_ready = 1'b1;

`ifdef DSO_RDR_HEADER_EN
        exp_b.push_back(8'hA5);
        exp_b.push_back(8'(PRE % WORDS));
        exp_lat = 1;
`else
        exp_lat = 3;
`endif
        for (int i = 0; i < WORDS; i++) begin
            logic [DEPTH-1:0] a;
            a = DEPTH'((int'(trig) - PRE + i + WORDS) % WORDS);
            exp_a.push_back(a);
            exp_b.push_back(mem[a][15:8]);
            exp_b.push_back(mem[a][7:0]);
        end

        checkOutput("frame_done", 32'(done), 32'd1);
        checkOutput("first_valid_latency", lat, exp_lat);
        checkOutput("byte_count", got_bytes.size(), exp_b.size());
        checkOutput("rd_en_count", got_addrs.size(), WORDS);
        for (int i = 0; i < exp_b.size() && i < got_bytes.size(); i++)
            checkOutput($sformatf("byte[%0d]", i), 32'(got_bytes[i]), 32'(exp_b[i]));
        for (int i = 0; i < WORDS && i < got_addrs.size(); i++)
            checkOutput($sformatf("rd_addr[%0d]", i), 32'(got_addrs[i]), 32'(exp_a[i]));
        checkOutput("stall_stability", stab_err, 0);
        checkOutput("busy_vs_ready", busy_err, 0);
    endtask

    initial begin
        vec_cnt       = 0;
        miss_cnt      = 0;
        rst           = 1'b1;
        capture_valid = 1'b0;
        trig_addr     = '0;
        out_ready     = 1'b1;
        stab_err      = 0;
        fillBuffer();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_capture_ready", 32'(capture_ready), 32'd0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_rd_en", 32'(rd_en), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset", 32'(capture_ready), 32'd1);

        // Plain frame, trigger mid-buffer
        runFrame(6'h10, 1'b0, 1'b0, -1);

        // Start address wraps below zero
        fillBuffer();
        runFrame(6'h03, 1'b0, 1'b0, -1);

        // Random receiver back-pressure
        fillBuffer();
        runFrame(6'h10, 1'b1, 1'b0, -1);

        // Reset in the middle of a frame
        fillBuffer();
        runFrame(6'h10, 1'b0, 1'b0, 40);
        rst = 1'b1;
        #1;
        checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_rd_en", 32'(rd_en), 32'd0);
        checkOutput("abort_capture_ready", 32'(capture_ready), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("abort_ready_before_edge", 32'(capture_ready), 32'd0);
        @(negedge clk);
        checkOutput("abort_ready_after_edge", 32'(capture_ready), 32'd1);
        checkOutput("abort_no_restart", 32'(busy), 32'd0);
        runFrame(6'h2C, 1'b0, 1'b0, -1);

        // capture_valid held and trig_addr changed during the frame
        fillBuffer();
        runFrame(6'h10, 1'b0, 1'b1, -1);

        // Random triggers with random back-pressure
        for (int k = 0; k < 2; k++) begin
            fillBuffer();
            runFrame(DEPTH'($urandom), 1'b1, 1'b0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
